// File: rtl/pattern_gen.sv
// Video timing and test-pattern generator: sync/DE timing, eight pattern modes and a latency-tester box.
// All outputs are registered, so each output reflects the counter state of the previous clock.
module pattern_gen #(
  parameter int   H_SYNCLEN   = 62,
  parameter int   H_BACKPORCH = 60,
  parameter int   H_ACTIVE    = 720,
  parameter int   H_TOTAL     = 858,
  parameter int   V_SYNCLEN   = 6,
  parameter int   V_BACKPORCH = 30,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_TOTAL     = 525,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter int   CW          = 11,
  parameter int   LT_WDIV     = 8,
  parameter int   LT_HDIV     = 8,
  parameter int   BAR_W       = 16
) (
  input  logic          clk27,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [2:0]    mode,
  input  logic [23:0]   fg_color,
  input  logic          lt_active,
  input  logic [1:0]    lt_mode,
  output logic [7:0]    R_out,
  output logic [7:0]    G_out,
  output logic [7:0]    B_out,
  output logic          HSYNC_out,
  output logic          VSYNC_out,
  output logic          DE_out,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int AW = CW + 8;
  typedef logic [AW-1:0] aw_t;

  localparam aw_t H_SYNC  = aw_t'(H_SYNCLEN);
  localparam aw_t H_ST    = aw_t'(H_SYNCLEN + H_BACKPORCH);
  localparam aw_t H_END   = aw_t'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam aw_t H_LAST  = aw_t'(H_TOTAL - 1);
  localparam aw_t V_SYNC  = aw_t'(V_SYNCLEN);
  localparam aw_t V_ST    = aw_t'(V_SYNCLEN + V_BACKPORCH);
  localparam aw_t V_END   = aw_t'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam aw_t V_LAST  = aw_t'(V_TOTAL - 1);
  localparam aw_t HA      = aw_t'(H_ACTIVE);
  localparam aw_t HA_LAST = aw_t'(H_ACTIVE - 1);
  localparam aw_t VA      = aw_t'(V_ACTIVE);
  localparam aw_t LT_W    = aw_t'(H_ACTIVE / LT_WDIV);
  localparam aw_t LT_H    = aw_t'(V_ACTIVE / LT_HDIV);
  localparam aw_t BAR     = aw_t'(BAR_W);
  localparam aw_t SAT     = aw_t'(255);

  logic [CW-1:0] h_cnt, v_cnt, bar_x;
  logic [2:0]    cur_mode;

  aw_t  h_ext, v_ext, bx_ext, x_a, y_a, x8, gray_w, box_x, box_y;
  logic h_last, v_last, fb, act, in_box;
  logic [2:0]  bar_idx;
  logic [7:0]  gray;
  logic [23:0] bar_rgb, rgb;

  assign h_ext  = aw_t'(h_cnt);
  assign v_ext  = aw_t'(v_cnt);
  assign bx_ext = aw_t'(bar_x);
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);
  assign fb     = enable && h_last && v_last;
  assign act    = enable && (h_ext >= H_ST) && (h_ext < H_END) &&
                  (v_ext >= V_ST) && (v_ext < V_END);

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // Mode and bar position only move at the frame boundary so a frame is never torn.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      cur_mode    <= '0;
      bar_x       <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= fb;
      if (fb) begin
        cur_mode  <= mode;
        frame_cnt <= frame_cnt + 8'd1;
        bar_x     <= (bx_ext == HA_LAST) ? '0 : bar_x + CW'(1);
      end
    end
  end

  always_comb begin
    x_a = '0;
    y_a = '0;
    if (act) begin
      x_a = h_ext - H_ST;
      y_a = v_ext - V_ST;
    end
  end

  // Bar index = floor(x*8/H_ACTIVE), found by threshold compares instead of a divider.
  always_comb begin
    x8      = x_a << 3;
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x8 >= aw_t'(i * H_ACTIVE)) bar_idx = 3'(i);
    end
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    gray_w = (x_a << 8) / HA;
    gray   = (gray_w > SAT) ? 8'hFF : gray_w[7:0];
  end

  always_comb begin
    box_x = '0;
    box_y = '0;
    case (lt_mode)
      2'd2: begin
        box_x = (HA - LT_W) >> 1;
        box_y = (VA - LT_H) >> 1;
      end
      2'd3: begin
        box_x = HA - LT_W;
        box_y = VA - LT_H;
      end
      default: begin
        box_x = '0;
        box_y = '0;
      end
    endcase
    in_box = (lt_mode != 2'd0) && (x_a >= box_x) && (x_a < box_x + LT_W) &&
             (y_a >= box_y) && (y_a < box_y + LT_H);
  end

  // The latency-tester override is deliberately not frame-latched.
  always_comb begin
    rgb = 24'h000000;
    if (lt_active) begin
      rgb = in_box ? 24'hFFFFFF : 24'h000000;
    end else begin
      case (cur_mode)
        3'd1: rgb = fg_color;
        3'd2: rgb = bar_rgb;
        3'd3: rgb = (x_a[4] ^ y_a[4]) ? 24'hFFFFFF : 24'h000000;
        3'd4: rgb = ((x_a[3:0] == 4'd0) || (y_a[3:0] == 4'd0)) ? fg_color : 24'h000000;
        3'd5: rgb = ((x_a >= bx_ext) && (x_a < bx_ext + BAR)) ? 24'hFFFFFF : 24'h000000;
        3'd6: rgb = {gray, gray, gray};
        default: rgb = 24'h000000;
      endcase
    end
    if (!act) rgb = 24'h000000;
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      HSYNC_out <= HSYNC_POL;
      VSYNC_out <= VSYNC_POL;
      DE_out    <= 1'b0;
      xpos      <= '0;
      ypos      <= '0;
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
    end else begin
      HSYNC_out <= (enable && (h_ext < H_SYNC)) ? HSYNC_POL : ~HSYNC_POL;
      VSYNC_out <= (enable && (v_ext < V_SYNC)) ? VSYNC_POL : ~VSYNC_POL;
      DE_out    <= act;
      xpos      <= x_a[CW-1:0];
      ypos      <= y_a[CW-1:0];
      {R_out, G_out, B_out} <= rgb;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen with a reduced raster; a frame-position reference model predicts every output each cycle.
module tb_pattern_gen;

  localparam int HS = 4, HB = 4, HA = 32, HT = 44;
  localparam int VS = 2, VB = 3, VA = 20, VT = 28;
  localparam int WD = 8, HD = 4, BW = 6, CW = 11;
  localparam int FT = HT * VT;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  localparam logic [57:0] RST_VEC = '0;

  logic          clk27 = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [23:0]   fg_color = 24'h0;
  logic          lt_active = 1'b0;
  logic [1:0]    lt_mode = 2'd0;
  logic [7:0]    R_out, G_out, B_out, frame_cnt;
  logic          HSYNC_out, VSYNC_out, DE_out, frame_start;
  logic [CW-1:0] xpos, ypos;

  int checks = 0;
  int errors = 0;
  int m_p = 0;
  int m_frames = 0;
  int m_mode = 0;

  always #5 clk27 = ~clk27;

  pattern_gen #(
    .H_SYNCLEN(HS), .H_BACKPORCH(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNCLEN(VS), .V_BACKPORCH(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW),
    .LT_WDIV(WD), .LT_HDIV(HD), .BAR_W(BW)
  ) dut (
    .clk27(clk27), .reset_n(reset_n), .enable(enable), .mode(mode),
    .fg_color(fg_color), .lt_active(lt_active), .lt_mode(lt_mode),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DE_out(DE_out),
    .xpos(xpos), .ypos(ypos), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  function automatic logic [23:0] pix(int x, int y, int md, logic [23:0] fg,
                                      logic lt, int ltm, int bar);
    int w, hh, x0, y0, g;
    logic [7:0] g8;
    if (lt) begin
      w = HA / WD;
      hh = VA / HD;
      case (ltm)
        1: begin x0 = 0; y0 = 0; end
        2: begin x0 = (HA - w) / 2; y0 = (VA - hh) / 2; end
        3: begin x0 = HA - w; y0 = VA - hh; end
        default: return 24'h0;
      endcase
      return (x >= x0 && x < x0 + w && y >= y0 && y < y0 + hh) ? WHITE : 24'h0;
    end
    case (md)
      1: return fg;
      2: return BARS[x * 8 / HA];
      3: return (((x / 16) % 2) != ((y / 16) % 2)) ? WHITE : 24'h0;
      4: return ((x % 16 == 0) || (y % 16 == 0)) ? fg : 24'h0;
      5: return (x >= bar && x < bar + BW) ? WHITE : 24'h0;
      6: begin
        g = x * 256 / HA;
        if (g > 255) g = 255;
        g8 = 8'(g);
        return {g8, g8, g8};
      end
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [57:0] expect_out(int p, logic en, int md, logic [23:0] fg,
                                             logic lt, int ltm, int bar, logic fs, int frames);
    int h, v, x, y;
    logic act, hs, vs;
    logic [23:0] rgb;
    h = p % HT;
    v = p / HT;
    act = en && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
    x = act ? h - (HS + HB) : 0;
    y = act ? v - (VS + VB) : 0;
    rgb = act ? pix(x, y, md, fg, lt, ltm, bar) : 24'h0;
    hs = (en && h < HS) ? 1'b0 : 1'b1;
    vs = (en && v < VS) ? 1'b0 : 1'b1;
    return {rgb, hs, vs, act, 11'(x), 11'(y), fs, 8'(frames % 256)};
  endfunction

  function automatic logic [57:0] observed();
    return {R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out, xpos, ypos, frame_start, frame_cnt};
  endfunction

  task automatic check(string tag, logic [57:0] obs, logic [57:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic end_sim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // One clock: predict from the model and the inputs held across the edge, then compare.
  task automatic step();
    logic fb;
    logic [57:0] e;
    fb = enable && (m_p == FT - 1);
    e = expect_out(m_p, enable, m_mode, fg_color, lt_active, int'(lt_mode),
                   m_frames % HA, fb, m_frames + (fb ? 1 : 0));
    if (fb) begin
      m_frames++;
      m_mode = int'(mode);
    end
    m_p = enable ? (m_p + 1) % FT : 0;
    @(posedge clk27);
    #1;
    check("cycle", observed(), e);
    if (errors > 40) end_sim();
  endtask

  task automatic run(int n, bit churn);
    for (int i = 0; i < n; i++) begin
      step();
      if (churn) begin
        if ($urandom_range(0, 149) == 0) begin
          mode      = 3'($urandom_range(0, 7));
          fg_color  = 24'($urandom);
          lt_active = ($urandom_range(0, 3) == 0);
          lt_mode   = 2'($urandom_range(0, 3));
        end
        if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
        else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    #3;
    check("reset_initial", observed(), RST_VEC);
    @(posedge clk27);
    @(posedge clk27);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;

    // Every mode, switched at varying points inside a frame.
    for (int md = 1; md < 8; md++) begin
      mode = 3'(md);
      fg_color = 24'($urandom);
      run(FT + int'($urandom_range(0, HT * 6)), 1'b0);
    end

    // Latency-tester box positions, changed mid-frame.
    lt_active = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lt_mode = 2'(k);
      run(FT / 2 + int'($urandom_range(0, HT)), 1'b0);
    end
    lt_active = 1'b0;

    // Idle then restart.
    enable = 1'b0;
    run(30, 1'b0);
    enable = 1'b1;
    run(FT / 3, 1'b0);

    run(3 * FT, 1'b1);
    enable    = 1'b1;
    lt_active = 1'b0;

    // Moving bar through a full wrap of its position.
    mode = 3'd5;
    run((HA + 2) * FT, 1'b0);

    // Mid-frame reset at line 10.
    n = 0;
    while (m_p != 10 * HT + 5 && n < 2 * FT) begin
      step();
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", observed(), RST_VEC);
    m_p = 0;
    m_frames = 0;
    m_mode = 0;
    @(posedge clk27);
    #1;
    check("reset_hold", observed(), RST_VEC);
    reset_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < FT + 10);
    check("frame_period", 58'(n), 58'(FT));
    check("frame_cnt_after_reset", 58'(frame_cnt), 58'd1);
    run(HT * 3, 1'b0);

    end_sim();
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_SYNCLEN 62, hsync width (px); H_BACKPORCH 60, h back porch; H_ACTIVE 720, active px; H_TOTAL 858, px per line.
  V_SYNCLEN 6, vsync lines; V_BACKPORCH 30, v back porch; V_ACTIVE 480, active lines; V_TOTAL 525, lines per frame.
  HSYNC_POL 0, hsync asserted level; VSYNC_POL 0, vsync asserted level.
  CW 11, counter/position width; LT_WDIV 8, LT_HDIV 8, latency-box size divisors; BAR_W 16, moving-bar width (px).
REQ-002 clk27  in  1  pixel clock; all logic on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  run counters; low holds generator idle.
REQ-005 mode  in  3  pattern select, sampled at frame boundary.
REQ-006 fg_color  in  24  {R,G,B} for solid and grid modes.
REQ-007 lt_active  in  1  latency-tester override; lt_mode  in  2  box position (0 black, 1 top-left, 2 center, 3 bottom-right).
REQ-008 R_out/G_out/B_out  out  8 each; HSYNC_out, VSYNC_out, DE_out  out  1; xpos, ypos  out  CW.
REQ-009 frame_start  out  1  one-cycle pulse; frame_cnt  out  8  completed-frame count.

Function
REQ-010 h_cnt counts 0..H_TOTAL-1 then wraps to 0; v_cnt increments when h_cnt==H_TOTAL-1, wraps at V_TOTAL-1.
REQ-011 Frame boundary (FB) is the cycle with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
REQ-012 All outputs registered; each output at cycle n+1 reflects counter state at cycle n (uniform 1-cycle latency, syncs/DE/RGB/xpos aligned).
REQ-013 HSYNC_out = HSYNC_POL while h_cnt<H_SYNCLEN, else ~HSYNC_POL; VSYNC_out likewise with v_cnt<V_SYNCLEN, VSYNC_POL.
REQ-014 DE_out high iff h_cnt in [H_SYNCLEN+H_BACKPORCH, +H_ACTIVE) and v_cnt in [V_SYNCLEN+V_BACKPORCH, +V_ACTIVE).
REQ-015 xpos = h_cnt-(H_SYNCLEN+H_BACKPORCH) and ypos = v_cnt-(V_SYNCLEN+V_BACKPORCH) while in active region; 0 otherwise.
REQ-016 RGB forced to 0 whenever DE_out is low.
REQ-017 mode latched into cur_mode at FB only; mid-frame mode changes have no visible effect until next frame.
REQ-018 Patterns by cur_mode: 0 black; 1 fg_color; 2 eight equal vertical bars W,Y,C,G,M,R,B,K, bar index = xpos*8/H_ACTIVE; 3 checkerboard, white when xpos[4]^ypos[4]; 4 fg_color where xpos[3:0]==0 or ypos[3:0]==0, else black; 5 white for xpos in [bar_x, bar_x+BAR_W), else black; 6 gray ramp R=G=B=xpos*256/H_ACTIVE saturated at 255; 7 black.
REQ-019 bar_x increments by 1 at each FB; at value H_ACTIVE-1 it wraps to 0; bar wider than remaining line is clipped, not wrapped.
REQ-020 lt_active=1 overrides mode: white box of H_ACTIVE/LT_WDIV x V_ACTIVE/LT_HDIV at top-left, centred, or bottom-right per lt_mode; lt_mode 0 all black; override takes effect next cycle (not frame-latched).
REQ-021 frame_start pulses high for exactly one cycle following FB; frame_cnt increments with it, wraps 255->0.
REQ-022 enable=0: h_cnt, v_cnt held at 0; syncs deasserted, DE_out 0, RGB 0, no frame_start; enable 0->1 starts at h_cnt=v_cnt=0 next cycle.
REQ-023 Widths: all intermediate arithmetic at CW+8 bits minimum, no truncation before compare.

Reset
REQ-024 reset_n low asynchronously clears h_cnt, v_cnt, bar_x, cur_mode, frame_cnt, xpos, ypos, RGB, DE_out, frame_start to 0 and drives HSYNC_out=HSYNC_POL, VSYNC_POL on VSYNC_out.
REQ-025 Reset asserted mid-frame aborts the frame; after release the first cycle counts from h_cnt=0, v_cnt=0.

Verification
REQ-026 Defaults, enable=1, 2 frames -> HSYNC low 62 cycles every 858; VSYNC low 6 lines; DE high 720x480 per frame; frame_start period 450450 cycles.
REQ-027 mode=2 -> line 36 of active: xpos 0..89 RGB FFFFFF, 90..179 FFFF00, 630..719 000000; DE edge aligned with first bar pixel.
REQ-028 mode switched 1->3 mid-frame -> fg_color persists to frame end; checkerboard from first active pixel of next frame.
REQ-029 mode=5 over 721 frames -> bar_x 0,1,..719,0; bar at 710 shows white xpos 710..719 only.
REQ-030 lt_active=1, lt_mode=2 -> white exactly xpos 315..404, ypos 210..269; lt_mode=0 -> all black.
REQ-031 reset_n pulsed low at v_cnt=200 -> outputs at reset values immediately; frame_cnt 0; next frame_start after exactly 450450 cycles from release.
